cache_controller: RTL and testbench

Per-cache control FSM that sits between the CPU request port and the cache metadata/data arrays. It consumes the metadata lookup results (valid_block_match, valid_dirty_bit) and generates every metadata control strobe, including miss_recovery_mode, the LRU update, valid/dirty set/clear and line install. On a miss it sequences an optional dirty-victim writeback and a multi-beat line fill over the memory port, then replays the lookup so the request completes as a hit.

---
 rtl/cache_controller_if.sv | 52 +++++
 rtl/cache_controller.sv | 130 +++++++++++++
 tb/tb_cache_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Handshake bundle between the cache controller, the CPU port,
// the metadata arrays and the memory port.
interface cache_controller_if #(
    parameter int WORDS_PER_LINE = 4
);
    localparam int IW = $clog2(WORDS_PER_LINE);

    logic          cpu_req_valid;
    logic          cpu_req_write;
    logic          cpu_req_ready;
    logic          cpu_resp_valid;
    logic          valid_block_match;
    logic          valid_dirty_bit;
    logic          miss_recovery_mode;
    logic          process_lru_counters;
    logic          clear_selected_valid_bit;
    logic          finish_new_line_install;
    logic          clear_selected_dirty_bit;
    logic          set_selected_dirty_bit;
    logic          data_we;
    logic          data_from_mem;
    logic [IW-1:0] word_idx;
    logic          mem_req_valid;
    logic          mem_req_write;
    logic          use_victim_tag;
    logic          mem_req_ready;
    logic          mem_resp_valid;

    modport master (
        output cpu_req_valid, cpu_req_write,
        output valid_block_match, valid_dirty_bit,
        output mem_req_ready, mem_resp_valid,
        input  cpu_req_ready, cpu_resp_valid,
        input  miss_recovery_mode, process_lru_counters,
        input  clear_selected_valid_bit, finish_new_line_install,
        input  clear_selected_dirty_bit, set_selected_dirty_bit,
        input  data_we, data_from_mem, word_idx,
        input  mem_req_valid, mem_req_write, use_victim_tag
    );

    modport slave (
        input  cpu_req_valid, cpu_req_write,
        input  valid_block_match, valid_dirty_bit,
        input  mem_req_ready, mem_resp_valid,
        output cpu_req_ready, cpu_resp_valid,
        output miss_recovery_mode, process_lru_counters,
        output clear_selected_valid_bit, finish_new_line_install,
        output clear_selected_dirty_bit, set_selected_dirty_bit,
        output data_we, data_from_mem, word_idx,
        output mem_req_valid, mem_req_write, use_victim_tag
    );
endinterface

// File: rtl/cache_controller.sv
// Per-cache control FSM: lookup, dirty-victim writeback, multi-beat
// line fill and replay of the lookup so every request ends as a hit.
module cache_controller #(
    parameter int WORDS_PER_LINE = 4,
    parameter bit READ_ONLY      = 1'b0
) (
    input logic         clk,
    input logic         reset,
    cache_controller_if.slave bus
);
    localparam int CW = $clog2(WORDS_PER_LINE);
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL_REQ,
        FILL_WAIT,
        INSTALL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;

        bus.cpu_req_ready            = 1'b0;
        bus.cpu_resp_valid           = 1'b0;
        bus.miss_recovery_mode       = 1'b0;
        bus.process_lru_counters     = 1'b0;
        bus.clear_selected_valid_bit = 1'b0;
        bus.finish_new_line_install  = 1'b0;
        bus.clear_selected_dirty_bit = 1'b0;
        bus.set_selected_dirty_bit   = 1'b0;
        bus.data_we                  = 1'b0;
        bus.data_from_mem            = 1'b0;
        bus.word_idx                 = cnt_q;
        bus.mem_req_valid            = 1'b0;
        bus.mem_req_write            = 1'b0;
        bus.use_victim_tag           = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    wr_d    = bus.cpu_req_write && !READ_ONLY;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.valid_block_match) begin
                    bus.process_lru_counters = 1'b1;
                    bus.cpu_resp_valid       = 1'b1;
                    if (wr_q) begin
                        bus.data_we                = 1'b1;
                        bus.set_selected_dirty_bit = !READ_ONLY;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = '0;
                    // A read-only cache never holds dirty data.
                    if (bus.valid_dirty_bit && !READ_ONLY)
                        state_d = WRITEBACK;
                    else
                        state_d = FILL_REQ;
                end
            end
            WRITEBACK: begin
                bus.miss_recovery_mode = 1'b1;
                bus.mem_req_valid      = 1'b1;
                bus.mem_req_write      = 1'b1;
                bus.use_victim_tag     = 1'b1;
                if (bus.mem_req_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        bus.clear_selected_dirty_bit = !READ_ONLY;
                        bus.clear_selected_valid_bit = 1'b1;
                        cnt_d   = '0;
                        state_d = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                bus.miss_recovery_mode       = 1'b1;
                bus.mem_req_valid            = 1'b1;
                bus.clear_selected_valid_bit = 1'b1;
                if (bus.mem_req_ready)
                    state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                bus.miss_recovery_mode = 1'b1;
                if (bus.mem_resp_valid) begin
                    bus.data_we       = 1'b1;
                    bus.data_from_mem = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = INSTALL;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end
            INSTALL: begin
                bus.miss_recovery_mode       = 1'b1;
                bus.finish_new_line_install  = 1'b1;
                bus.clear_selected_dirty_bit = !READ_ONLY;
                state_d = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: per-cycle vector table, directed miss,
// stall and reset sequences, and randomized traffic against a line model.
module tb_cache_controller;
    localparam int W = 4;

    typedef struct packed {
        logic       ready, resp, mrm, lru, clrv, fin;
        logic       clrd, setd, we, dfm;
        logic [1:0] idx;
        logic       mval, mwr, vict;
    } outs_t;

    typedef struct packed {
        logic [6:0] in;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int   sel = 0;
    logic rv = 0, rw = 0, hit_in = 0, dirty_in = 0;
    logic mr = 0, rs = 0;

    cache_controller_if #(.WORDS_PER_LINE(W)) b0 ();
    cache_controller_if #(.WORDS_PER_LINE(W)) b1 ();

    cache_controller #(.WORDS_PER_LINE(W), .READ_ONLY(1'b0)) dut0 (
        .clk(clk), .reset(rst), .bus(b0)
    );
    cache_controller #(.WORDS_PER_LINE(W), .READ_ONLY(1'b1)) dut1 (
        .clk(clk), .reset(rst), .bus(b1)
    );

    assign b0.cpu_req_valid     = rv && (sel == 0);
    assign b1.cpu_req_valid     = rv && (sel == 1);
    assign b0.cpu_req_write     = rw;
    assign b1.cpu_req_write     = rw;
    assign b0.valid_block_match = hit_in;
    assign b1.valid_block_match = hit_in;
    assign b0.valid_dirty_bit   = dirty_in;
    assign b1.valid_dirty_bit   = dirty_in;
    assign b0.mem_req_ready     = mr;
    assign b1.mem_req_ready     = mr;
    assign b0.mem_resp_valid    = rs;
    assign b1.mem_resp_valid    = rs;

    outs_t o0, o1, o;
    assign o0 = {b0.cpu_req_ready, b0.cpu_resp_valid, b0.miss_recovery_mode,
                 b0.process_lru_counters, b0.clear_selected_valid_bit,
                 b0.finish_new_line_install, b0.clear_selected_dirty_bit,
                 b0.set_selected_dirty_bit, b0.data_we, b0.data_from_mem,
                 b0.word_idx, b0.mem_req_valid, b0.mem_req_write,
                 b0.use_victim_tag};
    assign o1 = {b1.cpu_req_ready, b1.cpu_resp_valid, b1.miss_recovery_mode,
                 b1.process_lru_counters, b1.clear_selected_valid_bit,
                 b1.finish_new_line_install, b1.clear_selected_dirty_bit,
                 b1.set_selected_dirty_bit, b1.data_we, b1.data_from_mem,
                 b1.word_idx, b1.mem_req_valid, b1.mem_req_write,
                 b1.use_victim_tag};
    assign o = (sel == 1) ? o1 : o0;

    localparam outs_t IDLE_OUT = 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Metadata model of a 4-set direct-mapped cache, one per DUT.
    bit line_v[2][4];
    int line_t[2][4];
    bit line_d[2][4];
    int cur_set, cur_tag;
    bit use_model = 0;

    vec_t tab[19];

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive_meta();
        if (use_model) begin
            hit_in   = line_v[sel][cur_set] && line_t[sel][cur_set] == cur_tag;
            dirty_in = line_v[sel][cur_set] && line_d[sel][cur_set];
        end
    endtask

    task automatic run_txn(input int s, input int t, input bit wr,
                           input bit rnd, input int stall_idx,
                           input int stall_len, input bit abort,
                           output int lat, output int fin_rel,
                           output int fills);
        bit ro, hit, dirty, old_d;
        int n0, stalls, extra, wb, fa, fw, cw, sd, cd, ins, lru;
        int seq_err, stall_left, resp_cyc, d, lat_exp;
        int due[$];
        outs_t u;
        ro      = (sel == 1);
        hit     = line_v[sel][s] && line_t[sel][s] == t;
        dirty   = !hit && !ro && line_v[sel][s] && line_d[sel][s];
        old_d   = line_d[sel][s];
        stalls  = 0; extra = 0; wb = 0; fa = 0; fw = 0; cw = 0;
        sd = 0; cd = 0; ins = 0; lru = 0; seq_err = 0;
        stall_left = stall_len;
        resp_cyc = -1;
        fin_rel  = -1;
        cur_set = s; cur_tag = t; use_model = 1;
        rv = 1; rw = wr; rs = 0;
        drive_meta();
        n0 = cyc;
        for (int k = 0; k < 300 && resp_cyc < 0; k++) begin
            if (abort && fa == 3) begin
                rst = 1; rs = 0; mr = 0;
                @(posedge clk); #1;
                rst = 0; rv = 0;
                due.delete();
                lat = -1; fills = fa;
                return;
            end
            if (rnd)
                mr = $urandom_range(0, 2) != 0;
            else if (stall_left > 0 && o.mval && o.mwr && o.idx == stall_idx) begin
                mr = 0;
                stall_left--;
            end else
                mr = 1;
            rs = due.size() > 0 && due[0] == cyc;
            if (rs) void'(due.pop_front());
            @(negedge clk);
            if (k == 0 && !o.ready) seq_err++;
            if (k > 0 && o.ready) seq_err++;
            if (o.mval && !mr) stalls++;
            if (o.mval && o.mwr && mr) begin
                if (o.idx != wb) seq_err++;
                wb++;
            end
            if (o.mval && !o.mwr && mr) begin
                if (o.idx != fa) seq_err++;
                fa++;
                d = rnd ? $urandom_range(1, 3) : 1;
                extra += d - 1;
                due.push_back(cyc + d);
            end
            if (o.we && o.dfm) begin
                if (o.idx != fw) seq_err++;
                fw++;
            end
            if (o.we && !o.dfm) cw++;
            if (o.mval && (o.vict != o.mwr)) seq_err++;
            if (o.setd && o.clrd) seq_err++;
            if (o.clrv && o.fin) seq_err++;
            sd  += int'(o.setd);
            cd  += int'(o.clrd);
            lru += int'(o.lru);
            if (o.fin) begin
                ins++;
                fin_rel = cyc - n0;
            end
            if (o.resp) resp_cyc = cyc;
            u = o;
            @(posedge clk); #1;
            if (u.clrv) line_v[sel][s] = 0;
            if (u.fin) begin
                line_v[sel][s] = 1;
                line_t[sel][s] = t;
            end
            if (u.clrd) line_d[sel][s] = 0;
            if (u.setd) line_d[sel][s] = 1;
            if (resp_cyc >= 0) rv = 0;
            drive_meta();
        end
        rv = 0; mr = 0; rs = 0;
        lat   = resp_cyc - n0;
        fills = fa;
        lat_exp = hit ? 1 : 3 + (dirty ? W : 0) + 2 * W + stalls + extra;
        chk("latency", lat, lat_exp);
        chk("wb_beats", wb, dirty ? W : 0);
        chk("fill_reqs", fa, hit ? 0 : W);
        chk("fill_writes", fw, hit ? 0 : W);
        chk("cpu_writes", cw, (wr && !ro) ? 1 : 0);
        chk("set_dirty", sd, (wr && !ro) ? 1 : 0);
        chk("clr_dirty", cd, (ro || hit) ? 0 : (dirty ? 2 : 1));
        chk("install", ins, hit ? 0 : 1);
        chk("lru", lru, 1);
        chk("seq_err", seq_err, 0);
        chk("line_valid", int'(line_v[sel][s] && line_t[sel][s] == t), 1);
        if (!ro)
            chk("line_dirty", int'(line_d[sel][s]), int'(wr || (hit && old_d)));
        @(negedge clk);
        chk("resp_pulse", int'(o.resp), 0);
        chk("ready_after", int'(o.ready), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, fin_rel, fills;
        // {rst,rv,rw,match,dirty,mem_ready,mem_resp}, expected outputs
        tab[0]  = '{7'b0_0_0_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[1]  = '{7'b0_1_0_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[2]  = '{7'b0_1_0_1_0_0_0, 15'b0_1_0_1_0_0_0_0_0_0_00_0_0_0};
        tab[3]  = '{7'b0_0_0_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[4]  = '{7'b0_1_1_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[5]  = '{7'b0_1_1_1_0_0_0, 15'b0_1_0_1_0_0_0_1_1_0_00_0_0_0};
        tab[6]  = '{7'b0_0_0_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[7]  = '{7'b0_1_0_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[8]  = '{7'b0_1_0_0_1_0_0, 15'b0_0_0_0_0_0_0_0_0_0_00_0_0_0};
        tab[9]  = '{7'b0_1_0_0_0_0_0, 15'b0_0_1_0_0_0_0_0_0_0_00_1_1_1};
        tab[10] = '{7'b0_1_0_0_0_1_0, 15'b0_0_1_0_0_0_0_0_0_0_00_1_1_1};
        tab[11] = '{7'b0_1_0_0_0_1_0, 15'b0_0_1_0_0_0_0_0_0_0_01_1_1_1};
        tab[12] = '{7'b0_1_0_0_0_1_0, 15'b0_0_1_0_0_0_0_0_0_0_10_1_1_1};
        tab[13] = '{7'b0_1_0_0_0_1_0, 15'b0_0_1_0_1_0_1_0_0_0_11_1_1_1};
        tab[14] = '{7'b0_1_0_0_0_0_0, 15'b0_0_1_0_1_0_0_0_0_0_00_1_0_0};
        tab[15] = '{7'b0_1_0_0_0_1_0, 15'b0_0_1_0_1_0_0_0_0_0_00_1_0_0};
        tab[16] = '{7'b0_1_0_0_0_0_1, 15'b0_0_1_0_0_0_0_0_1_1_00_0_0_0};
        tab[17] = '{7'b1_1_0_0_0_0_0, 15'b0_0_1_0_1_0_0_0_0_0_01_1_0_0};
        tab[18] = '{7'b0_0_0_0_0_0_0, 15'b1_0_0_0_0_0_0_0_0_0_00_0_0_0};

        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset_ro_outputs", int'(o1), int'(IDLE_OUT));
        @(posedge clk); #1;

        sel = 0;
        use_model = 0;
        for (int i = 0; i < 19; i++) begin
            {rst, rv, rw, hit_in, dirty_in, mr, rs} = tab[i].in;
            @(negedge clk);
            n_chk++;
            if (o != tab[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %h, want %h", i, o, tab[i].exp);
            end
            @(posedge clk); #1;
        end

        run_txn(0, 1, 0, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("clean_miss_lat", lat, 11);
        chk("clean_miss_install", fin_rel, 10);
        run_txn(0, 1, 0, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("read_hit_lat", lat, 1);
        run_txn(0, 1, 1, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("write_hit_lat", lat, 1);
        run_txn(0, 2, 0, 0, 1, 3, 0, lat, fin_rel, fills);
        chk("dirty_stall_lat", lat, 18);

        run_txn(1, 0, 0, 0, 0, 0, 1, lat, fin_rel, fills);
        @(negedge clk);
        chk("abort_outputs", int'(o), int'(IDLE_OUT));
        @(posedge clk); #1;
        run_txn(1, 0, 0, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("refill_beats", fills, 4);
        chk("refill_lat", lat, 11);

        sel = 1;
        run_txn(0, 3, 1, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("ro_write_miss_lat", lat, 11);
        run_txn(0, 3, 1, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("ro_write_hit_lat", lat, 1);
        line_d[1][0] = 1;
        run_txn(0, 2, 1, 0, 0, 0, 0, lat, fin_rel, fills);
        chk("ro_no_writeback_lat", lat, 11);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 1);
            run_txn($urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1, 0, 0, 0,
                    lat, fin_rel, fills);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
